mem_arbiter: RTL and testbench

- Sits directly upstream of the single-port 16-bit program/data RAM and is the only block driving it.
- Arbitrates between the instruction-fetch port (read-only) and the load/store port (read/write) using a request/grant/response handshake.
- Drives the RAM's address, write data, write enable and read enable from registers, and captures the RAM's combinational read data.
- Flags accesses that fall outside the populated RAM depth.

---
 rtl/mem_arbiter_if.sv | 32 +++
 rtl/mem_arbiter.sv | 117 +++++++++++
 tb/tb_mem_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Request/grant/response bundle for the instruction-fetch (i_*) and load/store (d_*) ports.
// slave = arbiter side, master = requester side.
interface mem_arbiter_if #(
  parameter int AW = 12,
  parameter int DW = 16
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic          i_gnt;
  logic          i_rvalid;
  logic [DW-1:0] i_rdata;
  logic          i_err;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          d_err;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
    output i_gnt, i_rvalid, i_rdata, i_err, d_gnt, d_rvalid, d_rdata, d_err
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
    input  i_gnt, i_rvalid, i_rdata, i_err, d_gnt, d_rvalid, d_rdata, d_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between fetch and load/store ports in front of the single-port RAM.
// Optional store protection below TEXT_TOP when MEM_WPROT_EN is defined.
//
// state  | meaning
// IDLE   | no access in flight, arbitrate incoming requests
// ACCESS | RAM driven for the winner, winner's gnt high
// RESP   | winner's rvalid/err high, arbitrate the next request
module mem_arbiter #(
  parameter int            AW       = 12,
  parameter int            DW       = 16,
  parameter int            DEPTH    = 2048,
  parameter logic [AW-1:0] TEXT_TOP = 12'h400
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_we,
  output logic          ram_re,
  input  logic [DW-1:0] ram_rdata
);

`ifdef MEM_WPROT_EN
  localparam logic WPROT = 1'b1;
`else
  localparam logic WPROT = 1'b0;
`endif

  localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state;
  logic          last_d;
  logic          win_d;
  logic          cur_we;
  logic          cur_bad;

  logic          pick_d;
  logic [AW-1:0] sel_addr;
  logic          sel_we;
  logic          sel_bad;

  // On a tie the port that did not win last time goes first
  always_comb begin
    pick_d   = bus.d_req && (!bus.i_req || !last_d);
    sel_addr = pick_d ? bus.d_addr : bus.i_addr;
    sel_we   = pick_d && bus.d_we;
    sel_bad  = ({1'b0, sel_addr} >= DEPTH_LIM) ||
               (WPROT && sel_we && (sel_addr < TEXT_TOP));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_d       <= 1'b0;
      win_d        <= 1'b0;
      cur_we       <= 1'b0;
      cur_bad      <= 1'b0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
      ram_we       <= 1'b0;
      ram_re       <= 1'b0;
      bus.i_gnt    <= 1'b0;
      bus.i_rvalid <= 1'b0;
      bus.i_rdata  <= '0;
      bus.i_err    <= 1'b0;
      bus.d_gnt    <= 1'b0;
      bus.d_rvalid <= 1'b0;
      bus.d_rdata  <= '0;
      bus.d_err    <= 1'b0;
    end else begin
      bus.i_gnt    <= 1'b0;
      bus.d_gnt    <= 1'b0;
      bus.i_rvalid <= 1'b0;
      bus.d_rvalid <= 1'b0;
      bus.i_err    <= 1'b0;
      bus.d_err    <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (bus.i_req || bus.d_req) begin
            state     <= ACCESS;
            last_d    <= pick_d;
            win_d     <= pick_d;
            cur_we    <= sel_we;
            cur_bad   <= sel_bad;
            ram_addr  <= sel_addr;
            if (pick_d) ram_wdata <= bus.d_wdata;
            ram_we    <= sel_we && !sel_bad;
            ram_re    <= !sel_we && !sel_bad;
            bus.i_gnt <= !pick_d;
            bus.d_gnt <= pick_d;
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          state  <= RESP;
          ram_we <= 1'b0;
          ram_re <= 1'b0;
          if (win_d) begin
            bus.d_rvalid <= 1'b1;
            bus.d_err    <= cur_bad;
            if (!cur_we) bus.d_rdata <= cur_bad ? '0 : ram_rdata;
          end else begin
            bus.i_rvalid <= 1'b1;
            bus.i_err    <= cur_bad;
            bus.i_rdata  <= cur_bad ? '0 : ram_rdata;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural single-port RAM.
module tb_mem_arbiter;
  logic        clk;
  logic        rst_n;
  logic [11:0] ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_we;
  logic        ram_re;
  logic [15:0] ram_rdata;

  logic [15:0] mem [0:4095];
  int n_cmp = 0;
  int n_err = 0;
  int we_cnt = 0;
  int re_cnt = 0;
  int we0;
  int re0;

  mem_arbiter_if #(.AW(12), .DW(16)) bus ();

  mem_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_re    (ram_re),
    .ram_rdata (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ram_rdata = mem[ram_addr];
  always @(posedge clk) begin
    if (ram_we === 1'b1) mem[ram_addr] <= ram_wdata;
    if (ram_we === 1'b1) we_cnt++;
    if (ram_re === 1'b1) re_cnt++;
  end

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One load/store from IDLE: gnt cycle, response cycle, then back to idle.
  task automatic d_access(input string tag, input logic we, input logic [11:0] addr,
                          input logic [15:0] wdata, input logic exp_err,
                          input logic [15:0] exp_rdata, input logic ram_act);
    bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
    @(negedge clk);
    chk({tag, "_gnt"}, {bus.d_gnt, bus.i_gnt}, 2'b10);
    chk({tag, "_ram"}, {ram_we, ram_re}, ram_act ? {we, !we} : 2'b00);
    chk({tag, "_addr"}, ram_addr, addr);
    bus.d_req = 1'b0;
    @(negedge clk);
    chk({tag, "_rsp"}, {bus.d_rvalid, bus.d_err, bus.d_gnt, ram_we, ram_re}, {1'b1, exp_err, 3'b000});
    chk({tag, "_rdata"}, bus.d_rdata, exp_rdata);
    @(negedge clk);
    chk({tag, "_idle"}, {bus.d_rvalid, bus.d_gnt}, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'(i) ^ 16'h5A5A;
    mem[12'h005] = 16'hABCD;
    mem[12'h600] = 16'h6666;
    mem[12'h800] = 16'hBEEF;
    rst_n = 1'b0;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("reset_outs", {bus.i_gnt, bus.i_rvalid, bus.i_err, bus.i_rdata, bus.d_gnt, bus.d_rvalid,
                       bus.d_err, bus.d_rdata, ram_we, ram_re, ram_addr, ram_wdata}, 80'h0);
    rst_n = 1'b1;

    // Fetch of word 5
    @(negedge clk);
    bus.i_req = 1'b1; bus.i_addr = 12'h005;
    @(negedge clk);
    chk("fetch_gnt", {bus.i_gnt, bus.d_gnt, bus.i_rvalid, ram_re, ram_we}, 5'b10010);
    chk("fetch_addr", ram_addr, 12'h005);
    bus.i_req = 1'b0;
    @(negedge clk);
    chk("fetch_rsp", {bus.i_rvalid, bus.i_err, bus.i_gnt}, 3'b100);
    chk("fetch_rdata", bus.i_rdata, 16'hABCD);
    @(negedge clk);
    chk("fetch_idle", bus.i_rvalid, 1'b0);

    // Store then load back
    we0 = we_cnt;
    d_access("store500", 1'b1, 12'h500, 16'h1234, 1'b0, 16'h0000, 1'b1);
    chk("store500_mem", mem[12'h500], 16'h1234);
    chk("store500_wecnt", we_cnt - we0, 1);
    d_access("load500", 1'b0, 12'h500, 16'h0000, 1'b0, 16'h1234, 1'b1);

    // Both ports requesting continuously from reset: D, I, D, I
    rst_n = 1'b0;
    bus.i_req = 1'b1; bus.i_addr = 12'h020;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 12'h010;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rr_gnt", {bus.d_gnt, bus.i_gnt}, {k % 4 == 0, k % 4 == 2});
      chk("rr_rvalid", {bus.d_rvalid, bus.i_rvalid}, {k % 4 == 1, k % 4 == 3});
      if (k == 7) begin
        bus.i_req = 1'b0; bus.d_req = 1'b0;
      end
    end
    chk("rr_d_rdata", bus.d_rdata, 16'h5A4A);
    chk("rr_i_rdata", bus.i_rdata, 16'h5A7A);
    @(negedge clk);
    chk("rr_idle", {bus.d_gnt, bus.i_gnt, bus.d_rvalid, bus.i_rvalid}, 4'b0000);

    // Out-of-range load
    re0 = re_cnt;
    d_access("oor800", 1'b0, 12'h800, 16'h0000, 1'b1, 16'h0000, 1'b0);
    chk("oor800_recnt", re_cnt - re0, 0);

    // Reset during the ACCESS cycle of a store
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 12'h600; bus.d_wdata = 16'hDEAD;
    @(negedge clk);
    chk("midrst_gnt", {bus.d_gnt, ram_we}, 2'b11);
    bus.d_req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_clear", {bus.d_gnt, ram_we, ram_re}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_norsp", bus.d_rvalid, 1'b0);
    chk("midrst_mem", mem[12'h600], 16'h6666);
    bus.i_req = 1'b1; bus.i_addr = 12'h005;
    @(negedge clk);
    chk("midrst_idle_gnt", {bus.i_gnt, bus.d_rvalid}, 2'b10);
    bus.i_req = 1'b0;
    @(negedge clk);
    chk("midrst_fetch", {bus.i_rvalid, bus.i_rdata}, {1'b1, 16'hABCD});
    @(negedge clk);

    // Store around TEXT_TOP
`ifdef MEM_WPROT_EN
    d_access("wp3ff", 1'b1, 12'h3FF, 16'h7777, 1'b1, 16'h0000, 1'b0);
    chk("wp3ff_mem", mem[12'h3FF], 16'h59A5);
`else
    d_access("wp3ff", 1'b1, 12'h3FF, 16'h7777, 1'b0, 16'h0000, 1'b1);
    chk("wp3ff_mem", mem[12'h3FF], 16'h7777);
`endif
    d_access("wp400", 1'b1, 12'h400, 16'h8888, 1'b0, 16'h0000, 1'b1);
    chk("wp400_mem", mem[12'h400], 16'h8888);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
